scan_sequencer: RTL and testbench
=================================

# scan_sequencer

Consumes the scan parameters that the frame-parameter reader produces after the PC writes the configuration BRAM, and runs one OCT frame from them. It iterates lines, block repeats and points, and gives each point a fixed cycle budget. Within that budget it issues single-cycle DA-update, acquisition and CCD trigger strobes at programmed offsets. Sits between the parameter reader and the DAC/ADC/CCD trigger drivers.

## Interface
- No parameters; all counters and indices 16 bits.
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_valid  in  1  parameter-reader done flag (level or pulse); sampled only in IDLE
- x_points  in  16  points per block (xdata_points_number)
- x_blocks  in  16  block repeats per line (xdata_block_number)
- y_points  in  16  lines per frame (ydata_points_number)
- cycles_per_point  in  16  clk cycles per point
- da_delay  in  16  DA-update offset within point
- acq_delay  in  16  acquisition-trigger offset within point
- ccd_delay  in  16  CCD-trigger offset within first point of each block
- sys_state  in  16  bit0 run_en, bit1 continuous; other bits ignored
- busy  out  1  high in ARM/RUN
- x_idx, blk_idx, y_idx  out  16 each  current point, block, line
- da_update, acq_trig, ccd_trig  out  1 each  single-cycle strobes
- frame_done  out  1  one-cycle pulse at frame end
- cfg_err  out  1  sticky; set on rejected configuration

## Operation
- States: IDLE, ARM, RUN, DONE.
- IDLE:
  - If cfg_valid=1 and run_en=1, latch all parameter inputs and go to ARM.
  - Inputs are not latched at any other time.
- ARM:
  - If any latched x_points, x_blocks, y_points or cycles_per_point is 0: set cfg_err, return to IDLE.
  - Otherwise clear cfg_err, zero pc/x/blk/y, go to RUN.
- RUN, point counter pc 0..cpp-1:
  - da_update=1 when pc==da_delay.
  - acq_trig=1 when pc==acq_delay.
  - ccd_trig=1 when pc==ccd_delay and x_idx==0.
  - A delay ≥ cycles_per_point means that strobe never fires. Equal delays give coincident strobes.
- Index advance at pc==cpp-1, nested x, then blk, then y:
  - x wraps at x_points-1 and increments blk.
  - blk wraps at x_blocks-1 and increments y.
  - Wrap of y ends the frame and goes to DONE.
- DONE, one cycle:
  - frame_done=1.
  - If continuous=1 and run_en=1, return to RUN with indices zeroed and the same latched parameters. No re-latch.
  - Otherwise go to IDLE.
- Abort: run_en=0 sampled in ARM/RUN → IDLE next cycle. No frame_done; strobes cease immediately; indices hold last value.
- cfg_valid while not in IDLE is ignored.
- All arithmetic is unsigned 16-bit. Counters compare against latched value −1 and never overflow.

## Timing
- Reset values:
  - IDLE.
  - busy=0, all strobes=0, frame_done=0, cfg_err=0.
  - x_idx=blk_idx=y_idx=0.
  - Latched parameters=0.
- All outputs are registered. Strobe outputs are high in the cycle where internal pc equals the delay.
- Point start is the first RUN cycle of a point.
  - Indices change on the clock edge that begins the point.
  - da_update is high at point start + da_delay, and likewise for the other strobes.
- Latency:
  - cfg_valid sampled high at cycle N gives ARM at N+1 and first point start at N+2.
  - busy rises at N+1.
- Frame length: x_points·x_blocks·y_points·cycles_per_point RUN cycles, then 1 DONE cycle.
  - In continuous mode the next frame starts the cycle after DONE. Point cadence is one cycle longer across the frame boundary.
- cycles_per_point=1: pc is always 0. Strobes with delay 0 fire every cycle while RUN (acq/da) or on x_idx==0 cycles (ccd).
- Reset mid-frame: all outputs reset immediately (asynchronous assert). Restart requires a fresh cfg_valid.

## Test plan
- Basic frame: x=4, blk=1, y=2, cpp=10, da=0, acq=3, ccd=5, run_en=1, cont=0 → 8 da_update at 10-cycle spacing; acq_trig 3 cycles after each; 2 ccd_trig (x_idx=0 points); frame_done 80 cycles after first point start; busy falls with DONE.
- Zero config: y_points=0 → cfg_err=1 two cycles after cfg_valid, no strobes, returns to IDLE. A following valid config clears cfg_err.
- Out-of-range delay: cpp=4, acq_delay=4 → no acq_trig for whole frame; da_update still fires.
- Continuous: x=2, blk=2, y=1, cpp=3, cont=1 → frame_done every 13 cycles; indices sequence (x,blk) 00,10,01,11 repeating.
- Abort: deassert run_en mid-point of frame above → strobes stop next cycle, busy=0, no frame_done. cfg_valid held during RUN has no effect.
- Async reset mid-RUN → all outputs 0 within the reset cycle. No activity until the next cfg_valid with run_en=1.

Source files
------------

// File: rtl/scan_sequencer.sv
// OCT frame scan sequencer: walks lines, block repeats and points with a fixed
// cycle budget per point, firing DA-update / acquisition / CCD strobes at offsets.
module scan_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_valid,
    input  logic [15:0] x_points,
    input  logic [15:0] x_blocks,
    input  logic [15:0] y_points,
    input  logic [15:0] cycles_per_point,
    input  logic [15:0] da_delay,
    input  logic [15:0] acq_delay,
    input  logic [15:0] ccd_delay,
    input  logic [15:0] sys_state,
    output logic        busy,
    output logic [15:0] x_idx,
    output logic [15:0] blk_idx,
    output logic [15:0] y_idx,
    output logic        da_update,
    output logic        acq_trig,
    output logic        ccd_trig,
    output logic        frame_done,
    output logic        cfg_err
);
    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d, x_q, x_d, blk_q, blk_d, y_q, y_d;
    logic [15:0] xp_q, xp_d, xb_q, xb_d, yp_q, yp_d, cpp_q, cpp_d;
    logic [15:0] dad_q, dad_d, acqd_q, acqd_d, ccdd_q, ccdd_d;
    logic        busy_q, busy_d, da_q, da_d, acq_q, acq_d, ccd_q, ccd_d;
    logic        fd_q, fd_d, err_q, err_d;
    logic        run_en, cont, last_pc, last_x, last_blk, last_y, run_nxt;

    assign run_en   = sys_state[0];
    assign cont     = sys_state[1];
    assign last_pc  = (pc_q  == cpp_q - 16'd1);
    assign last_x   = (x_q   == xp_q  - 16'd1);
    assign last_blk = (blk_q == xb_q  - 16'd1);
    assign last_y   = (y_q   == yp_q  - 16'd1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        x_d     = x_q;
        blk_d   = blk_q;
        y_d     = y_q;
        xp_d    = xp_q;
        xb_d    = xb_q;
        yp_d    = yp_q;
        cpp_d   = cpp_q;
        dad_d   = dad_q;
        acqd_d  = acqd_q;
        ccdd_d  = ccdd_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (cfg_valid && run_en) begin
                    xp_d    = x_points;
                    xb_d    = x_blocks;
                    yp_d    = y_points;
                    cpp_d   = cycles_per_point;
                    dad_d   = da_delay;
                    acqd_d  = acq_delay;
                    ccdd_d  = ccd_delay;
                    state_d = ARM;
                end
            end
            ARM: begin
                if (!run_en) begin
                    state_d = IDLE;
                end else if (xp_q == '0 || xb_q == '0 || yp_q == '0 || cpp_q == '0) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    err_d   = 1'b0;
                    pc_d    = '0;
                    x_d     = '0;
                    blk_d   = '0;
                    y_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!run_en) begin
                    state_d = IDLE;
                end else if (last_pc) begin
                    // Point boundary: advance x, carrying into blk then y.
                    pc_d = '0;
                    if (!last_x) begin
                        x_d = x_q + 16'd1;
                    end else begin
                        x_d = '0;
                        if (!last_blk) begin
                            blk_d = blk_q + 16'd1;
                        end else begin
                            blk_d = '0;
                            if (!last_y) begin
                                y_d = y_q + 16'd1;
                            end else begin
                                y_d     = '0;
                                state_d = DONE;
                            end
                        end
                    end
                end else begin
                    pc_d = pc_q + 16'd1;
                end
            end
            DONE: begin
                if (cont && run_en) begin
                    pc_d    = '0;
                    x_d     = '0;
                    blk_d   = '0;
                    y_d     = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so decode against the next-cycle counters.
        run_nxt = (state_d == RUN);
        da_d    = run_nxt && (pc_d == dad_q);
        acq_d   = run_nxt && (pc_d == acqd_q);
        ccd_d   = run_nxt && (pc_d == ccdd_q) && (x_d == '0);
        busy_d  = (state_d == ARM) || run_nxt;
        fd_d    = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            x_q     <= '0;
            blk_q   <= '0;
            y_q     <= '0;
            xp_q    <= '0;
            xb_q    <= '0;
            yp_q    <= '0;
            cpp_q   <= '0;
            dad_q   <= '0;
            acqd_q  <= '0;
            ccdd_q  <= '0;
            busy_q  <= 1'b0;
            da_q    <= 1'b0;
            acq_q   <= 1'b0;
            ccd_q   <= 1'b0;
            fd_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            x_q     <= x_d;
            blk_q   <= blk_d;
            y_q     <= y_d;
            xp_q    <= xp_d;
            xb_q    <= xb_d;
            yp_q    <= yp_d;
            cpp_q   <= cpp_d;
            dad_q   <= dad_d;
            acqd_q  <= acqd_d;
            ccdd_q  <= ccdd_d;
            busy_q  <= busy_d;
            da_q    <= da_d;
            acq_q   <= acq_d;
            ccd_q   <= ccd_d;
            fd_q    <= fd_d;
            err_q   <= err_d;
        end
    end

    assign busy       = busy_q;
    assign x_idx      = x_q;
    assign blk_idx    = blk_q;
    assign y_idx      = y_q;
    assign da_update  = da_q;
    assign acq_trig   = acq_q;
    assign ccd_trig   = ccd_q;
    assign frame_done = fd_q;
    assign cfg_err    = err_q;
endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench for scan_sequencer: expected strobe/frame_done events are
// queued with their cycle and indices; a negedge monitor pops and compares.
module tb_scan_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [15:0] x_points = '0, x_blocks = '0, y_points = '0, cycles_per_point = '0;
    logic [15:0] da_delay = '0, acq_delay = '0, ccd_delay = '0, sys_state = '0;
    logic        busy, da_update, acq_trig, ccd_trig, frame_done, cfg_err;
    logic [15:0] x_idx, blk_idx, y_idx;

    scan_sequencer dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid),
        .x_points(x_points), .x_blocks(x_blocks), .y_points(y_points),
        .cycles_per_point(cycles_per_point), .da_delay(da_delay),
        .acq_delay(acq_delay), .ccd_delay(ccd_delay), .sys_state(sys_state),
        .busy(busy), .x_idx(x_idx), .blk_idx(blk_idx), .y_idx(y_idx),
        .da_update(da_update), .acq_trig(acq_trig), .ccd_trig(ccd_trig),
        .frame_done(frame_done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          t;
        int          kind;   // 0 da, 1 acq, 2 ccd, 3 frame_done
        logic [15:0] x, b, y;
    } ev_t;
    ev_t q[$];

    int n_chk = 0, n_pass = 0;

    task automatic check(input string name, input logic ok, input longint act, input longint exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Builds the expected event stream of one frame from first point start ps;
    // events after cycle 'cutoff' are dropped. Returns the next frame start.
    task automatic gen(input int ps, input int xp, input int bp, input int yp, input int cpp,
                       input int da, input int acq, input int ccd, input int cutoff,
                       output int next_ps);
        int t = ps;
        for (int yy = 0; yy < yp; yy++)
            for (int bb = 0; bb < bp; bb++)
                for (int xx = 0; xx < xp; xx++)
                    for (int pc = 0; pc < cpp; pc++) begin
                        if (t <= cutoff) begin
                            if (pc == da)  q.push_back('{t, 0, 16'(xx), 16'(bb), 16'(yy)});
                            if (pc == acq) q.push_back('{t, 1, 16'(xx), 16'(bb), 16'(yy)});
                            if (pc == ccd && xx == 0) q.push_back('{t, 2, 16'(xx), 16'(bb), 16'(yy)});
                        end
                        t++;
                    end
        if (t <= cutoff) q.push_back('{t, 3, 16'd0, 16'd0, 16'd0});
        next_ps = t + 1;
    endtask

    // Monitor: each asserted output consumes one queued event, in da/acq/ccd/fd order.
    always @(negedge clk) begin
        if (rst_n) begin
            logic [3:0] seen;
            seen = {frame_done, ccd_trig, acq_trig, da_update};
            for (int k = 0; k < 4; k++) begin
                if (seen[k]) begin
                    if (q.size() == 0) begin
                        check("unexpected_event", 1'b0, k, -1);
                    end else begin
                        ev_t e;
                        logic ok;
                        e = q.pop_front();
                        ok = (e.kind == k) && (e.t == cyc) && (busy == (k != 3));
                        if (k != 3) ok = ok && (x_idx == e.x) && (blk_idx == e.b) && (y_idx == e.y);
                        if (!ok)
                            $display("FAIL event: got kind=%0d t=%0d x=%0d b=%0d y=%0d busy=%0b expected kind=%0d t=%0d x=%0d b=%0d y=%0d",
                                     k, cyc, x_idx, blk_idx, y_idx, busy, e.kind, e.t, e.x, e.b, e.y);
                        n_chk++;
                        if (ok) n_pass++;
                    end
                end
            end
        end
    end

    // Drives one cfg_valid pulse; returns the expected first point start cycle.
    task automatic start(input int xp, input int bp, input int yp, input int cpp,
                         input int da, input int acq, input int ccd, input logic [15:0] sys,
                         output int ps);
        @(negedge clk);
        x_points = 16'(xp); x_blocks = 16'(bp); y_points = 16'(yp);
        cycles_per_point = 16'(cpp); da_delay = 16'(da); acq_delay = 16'(acq);
        ccd_delay = 16'(ccd); sys_state = sys; cfg_valid = 1'b1;
        ps = cyc + 2;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check(name, q.size() == 0, q.size(), 0);
        q.delete();
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    int ps, ps2, ps3, nx;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_busy",    busy == 1'b0, busy, 0);
        check("reset_cfg_err", cfg_err == 1'b0, cfg_err, 0);
        check("reset_idx",     {x_idx, blk_idx, y_idx} == '0, {x_idx, blk_idx, y_idx}, 0);
        check("reset_strobes", {da_update, acq_trig, ccd_trig, frame_done} == '0,
              {da_update, acq_trig, ccd_trig, frame_done}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // cfg_valid without run_en must not start anything
        start(4, 1, 2, 10, 0, 3, 5, 16'h0000, ps);
        repeat (5) @(negedge clk);
        check("no_run_en_busy", busy == 1'b0, busy, 0);

        // Basic frame
        gen(13 + cyc, 4, 1, 2, 10, 0, 3, 5, 1 << 30, nx);
        q.delete();
        start(4, 1, 2, 10, 0, 3, 5, 16'h0001, ps);
        gen(ps, 4, 1, 2, 10, 0, 3, 5, 1 << 30, nx);
        check("basic_arm_busy", busy == 1'b1, busy, 1);
        drain("basic_drain", 200);
        check("basic_idle_busy", busy == 1'b0, busy, 0);

        // Zero configuration
        start(4, 1, 0, 10, 0, 3, 5, 16'h0001, ps);
        check("zero_arm_err", cfg_err == 1'b0, cfg_err, 0);
        @(negedge clk);
        check("zero_cfg_err", cfg_err == 1'b1, cfg_err, 1);
        check("zero_busy", busy == 1'b0, busy, 0);
        drain("zero_drain", 10);

        // Out-of-range acq delay; valid config clears cfg_err
        start(1, 1, 1, 4, 1, 4, 9, 16'h0001, ps);
        gen(ps, 1, 1, 1, 4, 1, 4, 9, 1 << 30, nx);
        @(negedge clk);
        check("err_cleared", cfg_err == 1'b0, cfg_err, 0);
        drain("oor_drain", 20);

        // One cycle per point
        start(2, 1, 1, 1, 0, 0, 0, 16'h0001, ps);
        gen(ps, 2, 1, 1, 1, 0, 0, 0, 1 << 30, nx);
        drain("cpp1_drain", 20);

        // Continuous: two frames, then continuous dropped mid second frame
        start(2, 2, 1, 3, 0, 1, 2, 16'h0003, ps);
        gen(ps, 2, 2, 1, 3, 0, 1, 2, 1 << 30, ps2);
        gen(ps2, 2, 2, 1, 3, 0, 1, 2, 1 << 30, ps3);
        check("cont_period", ps2 - ps == 13, ps2 - ps, 13);
        wait_cyc(ps2 + 3);
        sys_state = 16'h0001;
        drain("cont_drain", 60);
        check("cont_idle_busy", busy == 1'b0, busy, 0);

        // Abort mid-point with cfg_valid held during RUN
        start(2, 2, 1, 3, 0, 1, 2, 16'h0003, ps);
        gen(ps, 2, 2, 1, 3, 0, 1, 2, ps + 7, nx);
        @(negedge clk);
        cfg_valid = 1'b1;
        wait_cyc(ps + 7);
        sys_state = 16'h0000;
        @(negedge clk);
        check("abort_busy", busy == 1'b0, busy, 0);
        check("abort_x_hold", x_idx == 16'd0, x_idx, 0);
        check("abort_blk_hold", blk_idx == 16'd1, blk_idx, 1);
        repeat (3) @(negedge clk);
        cfg_valid = 1'b0;
        @(negedge clk);
        sys_state = 16'h0001;
        drain("abort_drain", 20);

        // Asynchronous reset mid-RUN
        start(4, 1, 2, 10, 0, 3, 5, 16'h0001, ps);
        gen(ps, 4, 1, 2, 10, 0, 3, 5, ps + 23, nx);
        wait_cyc(ps + 23);
        #1 rst_n = 1'b0;
        #1;
        check("rst_outputs", {busy, da_update, acq_trig, ccd_trig, frame_done, cfg_err} == '0,
              {busy, da_update, acq_trig, ccd_trig, frame_done, cfg_err}, 0);
        check("rst_idx", {x_idx, blk_idx, y_idx} == '0, {x_idx, blk_idx, y_idx}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_stays_idle", busy == 1'b0, busy, 0);
        drain("rst_drain", 5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
